// File: rtl/kgp_isa_pkg.sv
// KGP-RISC ISA constants shared by the encoder/loader, the field packer and
// any bench that wants to speak in opcode names: opcode values, the bit
// positions of each field inside the 32-bit word, and the loader FSM states.
package kgp_isa_pkg;

  localparam logic [3:0] OP_ALU  = 4'b0000;
  localparam logic [3:0] OP_ALUI = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_BR   = 4'b0100;
  localparam logic [3:0] OP_JR   = 4'b0101;
  localparam logic [3:0] OP_BRR  = 4'b0110;

  // Opcode always occupies [31:28].
  localparam int OPC_LSB      = 28;
  // Two 5-bit register slots directly below the opcode: [27:23] and [22:18].
  localparam int SLOT_A_LSB   = 23;
  localparam int SLOT_B_LSB   = 18;
  // ALU: funcode at [17:14].
  localparam int ALU_FUN_LSB  = 14;
  // ALUI / BRR: imm at [22:7], funcode at [6:3].
  localparam int ALUI_IMM_LSB = 7;
  localparam int ALUI_FUN_LSB = 3;
  // LD / ST: imm at [17:2].
  localparam int MEM_IMM_LSB  = 2;
  // BR: imm at [27:12], funcode at [11:8].
  localparam int BR_IMM_LSB   = 12;
  localparam int BR_FUN_LSB   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Opcodes above BRR have no defined field layout.
  function automatic logic is_legal_op(input logic [3:0] op);
    return (op <= OP_BRR);
  endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Purely combinational packer: decoded fields -> 32-bit KGP-RISC word.
// Fields not used by an opcode's format are ignored; unlisted bits are 0.
// Unknown opcodes produce an opcode-only word.
module instr_field_packer
  import kgp_isa_pkg::*;
(
  input  logic [3:0]  opcode,
  input  logic [4:0]  reg1,
  input  logic [4:0]  reg2,
  input  logic [15:0] imm,
  input  logic [3:0]  funcode,
  output logic [31:0] word
);

  // Place each field according to the format selected by the opcode.
  always_comb begin
    word = '0;
    word[OPC_LSB +: 4] = opcode;
    case (opcode)
      OP_ALU: begin
        word[SLOT_A_LSB +: 5]  = reg1;
        word[SLOT_B_LSB +: 5]  = reg2;
        word[ALU_FUN_LSB +: 4] = funcode;
      end
      OP_ALUI, OP_BRR: begin
        word[SLOT_A_LSB +: 5]    = reg1;
        word[ALUI_IMM_LSB +: 16] = imm;
        word[ALUI_FUN_LSB +: 4]  = funcode;
      end
      OP_LD, OP_ST: begin
        // Memory ops carry reg2 in the first slot and reg1 in the second.
        word[SLOT_A_LSB +: 5]   = reg2;
        word[SLOT_B_LSB +: 5]   = reg1;
        word[MEM_IMM_LSB +: 16] = imm;
      end
      OP_BR: begin
        word[BR_IMM_LSB +: 16] = imm;
        word[BR_FUN_LSB +: 4]  = funcode;
      end
      OP_JR: begin
        word[SLOT_A_LSB +: 5] = reg1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts decoded instruction bundles on a valid/ready
// stream, packs them into 32-bit words and writes them to sequential
// instruction-memory addresses through a single output register that holds
// while the memory stalls.
// Optional build macro: ILLEGAL_OP_CHECK_EN -- when defined, bundles with an
// opcode above BRR are consumed but not written, and err pulses instead.
module instr_encoder_loader
  import kgp_isa_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int DEPTH     = 1024,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [3:0]        opcode,
  input  logic [4:0]        reg1,
  input  logic [4:0]        reg2,
  input  logic [15:0]       imm,
  input  logic [3:0]        funcode,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  input  logic              imem_ready,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              err
);

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

  state_t              state_reg, state_next;
  logic                wr_en_reg;
  logic [31:0]         wr_data_reg;
  logic [ADDR_W-1:0]   wr_addr_reg;
  logic [ADDR_W:0]     count_reg;
  logic                full_reg;
  logic                err_reg;

  logic [31:0]         packed_word;
  logic                accept;
  logic                write_done;
  logic                drop;
  logic [ADDR_W:0]     count_inc;
  logic [ADDR_W+1:0]   committed;
  logic                hits_depth;

  instr_field_packer u_packer (
    .opcode  (opcode),
    .reg1    (reg1),
    .reg2    (reg2),
    .imm     (imm),
    .funcode (funcode),
    .word    (packed_word)
  );

`ifdef ILLEGAL_OP_CHECK_EN
  assign drop = !is_legal_op(opcode);
`else
  assign drop = 1'b0;
`endif

  // Words already written plus the one sitting in the output register.
  assign committed  = {1'b0, count_reg} + (ADDR_W+2)'(wr_en_reg);
  assign count_inc  = count_reg + (ADDR_W+1)'(1);
  assign write_done = wr_en_reg && imem_ready;
  assign hits_depth = write_done && (count_inc == DEPTH_C);
  assign in_ready   = (state_reg == ST_LOAD) && (!wr_en_reg || imem_ready) &&
                      (committed < {1'b0, DEPTH_C});
  assign accept     = in_valid && in_ready;

  assign wr_en   = wr_en_reg;
  assign wr_addr = wr_addr_reg;
  assign wr_data = wr_data_reg;
  assign count   = count_reg;
  assign full    = full_reg;
  assign err     = err_reg;
  assign busy    = (state_reg == ST_LOAD) || (state_reg == ST_DRAIN);
  assign done    = (state_reg == ST_DONE);

  // Session FSM: LOAD until last bundle or depth reached, DRAIN until the
  // output register empties, then a single DONE cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_LOAD;
      ST_LOAD:  if ((accept && in_last) || hits_depth) state_next = ST_DRAIN;
      ST_DRAIN: if (!wr_en_reg) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State, output register, address/count bookkeeping and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      wr_en_reg   <= 1'b0;
      wr_data_reg <= '0;
      wr_addr_reg <= BASE_C;
      count_reg   <= '0;
      full_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      err_reg   <= accept && drop;

      if ((state_reg == ST_IDLE) && start) begin
        wr_addr_reg <= BASE_C;
        count_reg   <= '0;
        full_reg    <= 1'b0;
      end else if (write_done) begin
        wr_addr_reg <= wr_addr_reg + ADDR_W'(1);
        count_reg   <= count_inc;
        if (count_inc == DEPTH_C) full_reg <= 1'b1;
      end

      // A new bundle may replace the held word only in the cycle it drains,
      // which in_ready already guarantees.
      if (accept && !drop) begin
        wr_en_reg   <= 1'b1;
        wr_data_reg <= packed_word;
      end else if (write_done) begin
        wr_en_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader (DEPTH=4 so the full-stop case is
// short). Expected words are hand-computed constants.
module tb_instr_encoder_loader;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst, start, in_valid, in_last, imem_ready;
  logic [3:0]        opcode, funcode;
  logic [4:0]        reg1, reg2;
  logic [15:0]       imm;
  logic              in_ready, wr_en, busy, done, full, err;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [ADDR_W:0]   count;

  int n_chk = 0;
  int n_err = 0;
  int err_pulses = 0;
  logic [ADDR_W-1:0] log_addr[$];
  logic [31:0]       log_data[$];

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [15:0] im;
    logic [3:0]  fn;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last), .opcode(opcode), .reg1(reg1),
    .reg2(reg2), .imm(imm), .funcode(funcode), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .imem_ready(imem_ready),
    .busy(busy), .done(done), .full(full), .count(count), .err(err)
  );

  // Record every completed write and every err pulse.
  always @(posedge clk) begin
    if (!rst && wr_en && imem_ready) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
      $display("write addr=%0d data=0x%08h", wr_addr, wr_data);
    end
    if (!rst && err) err_pulses++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [3:0] op, input logic [4:0] r1, input logic [4:0] r2,
                            input logic [15:0] im, input logic [3:0] fn, input logic last);
    opcode = op; reg1 = r1; reg2 = r2; imm = im; funcode = fn; in_last = last;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Present a bundle and hold it until the handshake completes (bounded).
  task automatic send(input logic [3:0] op, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [15:0] im, input logic [3:0] fn, input logic last);
    bit ok = 1'b0;
    set_fields(op, r1, r2, im, fn, last);
    in_valid = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (in_ready) ok = 1'b1;
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (done) seen = 1'b1;
      else step();
    end
    chk(name, 32'(seen), 32'd1);
    step();
  endtask

  initial begin
    vecs[0] = '{4'b0000, 5'd3,  5'd5,  16'h0000, 4'h2, 32'h01948000};
    vecs[1] = '{4'b0001, 5'd1,  5'd0,  16'hFFFF, 4'hA, 32'h10FFFFD0};
    vecs[2] = '{4'b0010, 5'd2,  5'd4,  16'h0010, 4'h0, 32'h22080040};
    vecs[3] = '{4'b0100, 5'd0,  5'd0,  16'h1234, 4'h3, 32'h41234300};
    vecs[4] = '{4'b0011, 5'd7,  5'd31, 16'hABCD, 4'h0, 32'h3F9EAF34};
    vecs[5] = '{4'b0101, 5'd31, 5'd31, 16'hFFFF, 4'hF, 32'h5F800000};
    vecs[6] = '{4'b0110, 5'd16, 5'd0,  16'h8001, 4'h5, 32'h684000A8};
    vecs[7] = '{4'b0000, 5'd0,  5'd0,  16'hFFFF, 4'hF, 32'h0003C000};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; imem_ready = 1'b1;
    set_fields(4'h0, 5'd0, 5'd0, 16'h0, 4'h0, 1'b0);
    repeat (3) step();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_wr_en",    32'(wr_en),    32'd0);
    chk("rst_wr_addr",  32'(wr_addr),  32'd0);
    chk("rst_wr_data",  wr_data,       32'd0);
    chk("rst_count",    32'(count),    32'd0);
    chk("rst_flags",    {28'd0, busy, done, full, err}, 32'd0);

    // One single-bundle session per vector.
    for (int i = 0; i < 8; i++) begin
      do_start();
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
      set_fields(vecs[i].op, vecs[i].r1, vecs[i].r2, vecs[i].im, vecs[i].fn, 1'b1);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk($sformatf("v%0d_wr_en", i),   32'(wr_en),   32'd1);
      chk($sformatf("v%0d_wr_addr", i), 32'(wr_addr), 32'd0);
      chk($sformatf("v%0d_wr_data", i), wr_data,      vecs[i].exp);
      step();
      chk($sformatf("v%0d_done_early", i), 32'(done), 32'd0);
      step();
      chk($sformatf("v%0d_done", i),  32'(done),  32'd1);
      chk($sformatf("v%0d_count", i), 32'(count), 32'd1);
      step();
      chk($sformatf("v%0d_idle", i), {30'd0, busy, done}, 32'd0);
    end

    // Backpressure: first word held 3 cycles while a second bundle waits.
    log_addr.delete(); log_data.delete();
    do_start();
    imem_ready = 1'b0;
    set_fields(vecs[1].op, vecs[1].r1, vecs[1].r2, vecs[1].im, vecs[1].fn, 1'b0);
    in_valid = 1'b1;
    step();
    set_fields(vecs[2].op, vecs[2].r1, vecs[2].r2, vecs[2].im, vecs[2].fn, 1'b0);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp%0d_wr_en", c),    32'(wr_en),    32'd1);
      chk($sformatf("bp%0d_wr_addr", c),  32'(wr_addr),  32'd0);
      chk($sformatf("bp%0d_wr_data", c),  wr_data,       vecs[1].exp);
      chk($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
      if (c < 2) step();
    end
    imem_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    step();
    send(vecs[3].op, vecs[3].r1, vecs[3].r2, vecs[3].im, vecs[3].fn, 1'b1);
    wait_done("bp_done");
    chk("bp_count", 32'(count), 32'd3);
    chk("bp_nwrites", 32'(log_addr.size()), 32'd3);
    if (log_addr.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("bp_addr%0d", i), 32'(log_addr[i]), 32'(i));
        chk($sformatf("bp_data%0d", i), log_data[i], vecs[i+1].exp);
      end
    end

    // Depth limit: offer 6 bundles with no in_last; only 4 may be taken.
    begin
      int accepted = 0;
      bit done_seen = 1'b0;
      log_addr.delete(); log_data.delete();
      do_start();
      for (int c = 0; c < 12; c++) begin
        in_valid = (accepted < 6);
        set_fields(4'b0101, 5'(accepted + 1), 5'd0, 16'h0, 4'h0, 1'b0);
        #1;
        if (done) done_seen = 1'b1;
        if (in_valid && in_ready) accepted++;
        step();
      end
      in_valid = 1'b0;
      chk("full_accepted", 32'(accepted), 32'd4);
      chk("full_done_seen", 32'(done_seen), 32'd1);
      chk("full_flag", 32'(full), 32'd1);
      chk("full_count", 32'(count), 32'd4);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk("full_nwrites", 32'(log_addr.size()), 32'd4);
      if (log_addr.size() == 4) begin
        for (int i = 0; i < 4; i++) begin
          chk($sformatf("full_addr%0d", i), 32'(log_addr[i]), 32'(i));
          chk($sformatf("full_data%0d", i), log_data[i], 32'h50000000 | (32'(i + 1) << 23));
        end
      end
    end

    // Illegal opcode between two legal bundles.
    log_addr.delete(); log_data.delete();
    err_pulses = 0;
    do_start();
    chk("ill_full_cleared", 32'(full), 32'd0);
    send(vecs[0].op, vecs[0].r1, vecs[0].r2, vecs[0].im, vecs[0].fn, 1'b0);
    send(4'b1001, 5'd5, 5'd6, 16'hFFFF, 4'hF, 1'b0);
    send(vecs[3].op, vecs[3].r1, vecs[3].r2, vecs[3].im, vecs[3].fn, 1'b1);
    wait_done("ill_done");
`ifdef ILLEGAL_OP_CHECK_EN
    chk("ill_err_pulses", 32'(err_pulses), 32'd1);
    chk("ill_nwrites", 32'(log_addr.size()), 32'd2);
    if (log_addr.size() == 2) begin
      chk("ill_addr1", 32'(log_addr[1]), 32'd1);
      chk("ill_data1", log_data[1], vecs[3].exp);
    end
`else
    chk("ill_err_pulses", 32'(err_pulses), 32'd0);
    chk("ill_nwrites", 32'(log_addr.size()), 32'd3);
    if (log_addr.size() == 3) begin
      chk("ill_addr1", 32'(log_addr[1]), 32'd1);
      chk("ill_data1", log_data[1], 32'h90000000);
      chk("ill_data2", log_data[2], vecs[3].exp);
    end
`endif

    // start together with in_valid is not a handshake; then reset mid-LOAD.
    log_addr.delete(); log_data.delete();
    set_fields(vecs[4].op, vecs[4].r1, vecs[4].r2, vecs[4].im, vecs[4].fn, 1'b0);
    in_valid = 1'b1;
    start = 1'b1;
    #1;
    chk("st_in_ready_idle", 32'(in_ready), 32'd0);
    step();
    start = 1'b0;
    chk("st_no_accept", 32'(wr_en), 32'd0);
    step();
    set_fields(vecs[5].op, vecs[5].r1, vecs[5].r2, vecs[5].im, vecs[5].fn, 1'b0);
    step();
    in_valid = 1'b0;
    imem_ready = 1'b0;
    chk("mr_wr_en", 32'(wr_en), 32'd1);
    chk("mr_count", 32'(count), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    imem_ready = 1'b1;
    chk("mr_wr_en_after", 32'(wr_en), 32'd0);
    chk("mr_count_after", 32'(count), 32'd0);
    chk("mr_addr_after", 32'(wr_addr), 32'd0);
    chk("mr_busy_after", 32'(busy), 32'd0);
    repeat (5) step();
    chk("mr_nwrites", 32'(log_addr.size()), 32'd1);
    chk("mr_in_ready", 32'(in_ready), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
